// File: rtl/sdrc_pkg.sv
// sdrc_pkg: shared colbits encodings, sequencer states and page-mask helper
package sdrc_pkg;
  localparam logic [1:0] CB_8  = 2'b00;
  localparam logic [1:0] CB_9  = 2'b01;
  localparam logic [1:0] CB_10 = 2'b10;
  localparam logic [1:0] CB_11 = 2'b11;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic logic [11:0] page_mask(input logic [1:0] cb);
    return cb == CB_8 ? 12'h0ff : cb == CB_9 ? 12'h1ff : cb == CB_10 ? 12'h3ff : 12'h7ff;
  endfunction
endpackage

// File: rtl/sdrc_col_inc.sv
// sdrc_col_inc: combinational half-adder-chain incrementer, sum = a + 1
module sdrc_col_inc #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] sum
);
  logic cy;
  always_comb begin
    cy = 1'b1;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ cy;
      cy = cy & a[i];
    end
  end
endmodule

// File: rtl/sdrc_col_burst_gen.sv
// sdrc_col_burst_gen: issues one column per beat, stopping at the page boundary
module sdrc_col_burst_gen
  import sdrc_pkg::*;
#(
  parameter int COL_W = 12,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       cfg_colbits,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [COL_W-1:0] req_col,
  input  logic [LEN_W-1:0] req_len,
  output logic             beat_valid,
  input  logic             beat_ready,
  output logic [COL_W-1:0] beat_col,
  output logic             beat_last,
  output logic             done,
  output logic             split,
  output logic [COL_W-1:0] split_col,
  output logic [LEN_W-1:0] split_len
);
  state_t           state;
  logic [COL_W-1:0] col, col_nxt, pm;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       cb;
  logic             page_end, cnt_one;
  sdrc_col_inc #(.W(COL_W)) u_inc (.a(col), .sum(col_nxt));
  assign pm         = COL_W'(page_mask(cb));
  assign page_end   = (col & pm) == pm;
  assign cnt_one    = cnt == LEN_W'(1);
  assign req_ready  = state == IDLE;
  assign beat_valid = state == BURST;
  assign beat_col   = col;
  assign beat_last  = beat_valid & (cnt_one | page_end);
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      cnt       <= '0;
      cb        <= '0;
      done      <= 1'b0;
      split     <= 1'b0;
      split_col <= '0;
      split_len <= '0;
    end else begin
      done  <= 1'b0;
      split <= 1'b0;
      if (state == IDLE) begin
        if (req_valid && req_len != '0) begin
          col   <= req_col;
          cnt   <= req_len;
          cb    <= cfg_colbits;
          state <= BURST;
        end else if (req_valid) begin
          done <= 1'b1;
        end
      end else if (beat_ready) begin
        // last beat wins over a coincident page end: no split with nothing left
        if (cnt_one) begin
          state <= IDLE;
          done  <= 1'b1;
        end else if (page_end) begin
          state     <= IDLE;
          split     <= 1'b1;
          split_col <= col_nxt;
          split_len <= cnt - LEN_W'(1);
        end else begin
          col <= col_nxt;
          cnt <= cnt - LEN_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_sdrc_col_burst_gen.sv
// tb_sdrc_col_burst_gen: random and directed bursts against a page-arithmetic reference model
module tb_sdrc_col_burst_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cfg_colbits = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_col = '0;
  logic [7:0]  req_len = '0;
  logic        beat_valid;
  logic        beat_ready = 1'b0;
  logic [11:0] beat_col;
  logic        beat_last;
  logic        done;
  logic        split;
  logic [11:0] split_col;
  logic [7:0]  split_len;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sdrc_col_burst_gen dut (
    .clk(clk), .reset(reset), .cfg_colbits(cfg_colbits),
    .req_valid(req_valid), .req_ready(req_ready), .req_col(req_col), .req_len(req_len),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_col(beat_col), .beat_last(beat_last),
    .done(done), .split(split), .split_col(split_col), .split_len(split_len)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Called at a negedge with the block idle; returns at the negedge of the done/split cycle.
  task automatic burst(input int col, input int len, input int cb, input bit rnd,
                       input logic [7:0] pat, input int npat);
    int ps, rem, seg, idx, k, guard;
    ps  = 1 << (8 + cb);
    rem = ps - (col % ps);
    seg = (len < rem) ? len : rem;
    chk("req_ready_idle", 32'(req_ready), 1);
    cfg_colbits = 2'(cb);
    req_col     = 12'(col);
    req_len     = 8'(len);
    req_valid   = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    idx = 0;
    k = 0;
    guard = 0;
    while (idx < seg && guard < 2000) begin
      chk("beat_valid", 32'(beat_valid), 1);
      chk("beat_col", 32'(beat_col), 32'((col + idx) % 4096));
      chk("beat_last", 32'(beat_last), 32'(idx == seg - 1));
      chk("req_ready_busy", 32'(req_ready), 0);
      chk("no_pulse_mid", 32'({done, split}), 0);
      beat_ready = (k < npat) ? pat[k] : (rnd ? 1'($urandom % 2) : 1'b1);
      req_valid  = 1'($urandom % 2);
      req_len    = 8'($urandom);
      if (beat_ready) idx++;
      k++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 2000) chk("beat_timeout", 1, 0);
    beat_ready = 1'b0;
    req_valid  = 1'b0;
    chk("end_beat_valid", 32'(beat_valid), 0);
    chk("end_req_ready", 32'(req_ready), 1);
    chk("done", 32'(done), 32'(seg == len));
    chk("split", 32'(split), 32'(seg != len));
    if (seg != len) begin
      chk("split_col", 32'(split_col), 32'((col + seg) % 4096));
      chk("split_len", 32'(split_len), 32'(len - seg));
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_beat_valid", 32'(beat_valid), 0);
    chk("rst_beat_last", 32'(beat_last), 0);
    chk("rst_beat_col", 32'(beat_col), 0);
    chk("rst_pulses", 32'({done, split}), 0);
    chk("rst_split_data", 32'({split_col, split_len}), 0);
    burst(12'h010, 4, 0, 1'b0, 8'h00, 0);
    burst(12'h0FE, 5, 0, 1'b0, 8'h00, 0);
    burst(12'h020, 3, 0, 1'b0, 8'b1001, 4);
    burst(12'hFFF, 2, 3, 1'b0, 8'h00, 0);
    burst(12'h123, 0, 1, 1'b0, 8'h00, 0);
    burst(12'h0FF, 1, 0, 1'b0, 8'h00, 0);
    burst(12'h1FE, 7, 1, 1'b1, 8'h00, 0);
    burst(12'h3F0, 255, 2, 1'b0, 8'h00, 0);
    // reset during the stall of beat 2
    @(negedge clk);
    cfg_colbits = 2'b00; req_col = 12'h020; req_len = 8'd3; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; beat_ready = 1'b1;
    @(negedge clk);
    beat_ready = 1'b0;
    chk("pre_rst_beat_col", 32'(beat_col), 32'h021);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_beat_valid", 32'(beat_valid), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 1);
    chk("mid_rst_pulses", 32'({done, split}), 0);
    @(negedge clk);
    chk("post_rst_pulses", 32'({done, split}), 0);
    burst(12'h040, 3, 0, 1'b0, 8'h00, 0);
    for (int i = 0; i < 200; i++)
      burst(int'($urandom_range(0, 4095)), ($urandom % 8 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12)),
            int'($urandom_range(0, 3)), 1'b1, 8'h00, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdrc_col_burst_gen.md
# sdrc_col_burst_gen

Column-address burst sequencer for the SDRAM transfer controller. Accepts a transfer request (start column, beat count), then issues one column address per accepted beat to the command/data path. It advances the column with a full-width incrementer and stops at the SDRAM page boundary selected by `cfg_colbits`. When a burst crosses a page, the block reports the remaining length and the next column so the upstream controller can open the next row.

## Interface

**Parameters**
- `COL_W`, default 12: column address width.
- `LEN_W`, default 8: beat-count width.

**Ports**
- `clk` input, 1: single clock. All logic is on the rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `cfg_colbits` input, 2: page size select. 00 = 8, 01 = 9, 10 = 10, 11 = 11 column bits. Sampled at request accept.
- `req_valid` input, 1: transfer request.
- `req_ready` output, 1: block is idle and can accept a request.
- `req_col` input, COL_W: start column.
- `req_len` input, LEN_W: number of beats. 0 is legal.
- `beat_valid` output, 1: `beat_col` is valid.
- `beat_ready` input, 1: downstream accepts the beat.
- `beat_col` output, COL_W: column for this beat.
- `beat_last` output, 1: current beat is the final beat of this page segment.
- `done` output, 1: one-cycle pulse when the full length has been issued.
- `split` output, 1: one-cycle pulse when the page boundary was hit with beats remaining.
- `split_col` output, COL_W: next column after the split. Valid while `split`=1.
- `split_len` output, LEN_W: remaining beats after the split. Valid while `split`=1.

## Operation

**State machine**

IDLE:
- `req_ready`=1.
- Handshake is `req_valid`&`req_ready`.
- If `req_len`≠0: load `col`←`req_col`, `cnt`←`req_len`, latch `cfg_colbits`, go to BURST.
- If `req_len`=0: pulse `done` the next cycle and stay in IDLE.

BURST:
- `beat_valid`=1, `beat_col`=`col`.
- `req_ready`=0. `req_valid` is ignored.
- `beat_last` = (`cnt`==1) | `page_end`.
- `page_end` = low (latched colbits) bits of `col` are all ones.

On beat handshake (`beat_valid`&`beat_ready`):
- If `cnt`==1: go to IDLE, pulse `done`. This takes priority over `page_end`.
- Else if `page_end`: go to IDLE, pulse `split`, `split_col`←`col`+1, `split_len`←`cnt`−1.
- Otherwise: `col`←`col`+1, `cnt`←`cnt`−1, stay in BURST.

**Arithmetic**
- The increment spans the full COL_W width, modulo 2^COL_W. A carry out of bit 11 wraps to 0.
- `split_col` therefore carries into bits above the page field.
- `cnt` is never decremented below 1 in BURST.

**Reset**
- All outputs 0 except `req_ready`=1. State is IDLE, `col` and `cnt` are 0.
- Reset asserted mid-burst returns the block to IDLE at the next edge. No `done` or `split` is emitted.

## Timing

- Request accepted at edge N → `beat_valid`=1 in cycle N+1 with `beat_col`=`req_col`.
- One beat per cycle while `beat_ready`=1. `beat_ready`=0 stalls the sequence, with `beat_col` held stable.
- The `done` or `split` pulse appears in the cycle after the final handshake. `req_ready` returns to 1 in that same cycle.
- A new request may be accepted in the cycle `done`/`split` is high, so back-to-back bursts have one bubble cycle.
- `req_len`=0: `done` pulses in cycle N+1, with no beats.
- `beat_valid` never drops without a handshake.

## Structure

- Shared package `sdrc_pkg` holds:
  - The `cfg_colbits` encoding constants.
  - The state enum (IDLE, BURST).
  - A function returning the page mask for a given colbits value.
- One sub-module, `sdrc_col_inc`: a combinational COL_W-bit incrementer (half-adder chain, `SUM`=`A`+1). It is used for `col` advance and `split_col`.
- Outputs are registered, except `beat_last`, which is decoded from registered `col`/`cnt`.

## Test plan

- `cfg_colbits`=00, `req_col`=0x010, `req_len`=4, `beat_ready`=1 → beats 0x010–0x013, `beat_last` on 0x013, `done` the next cycle, no `split`.
- `cfg_colbits`=00, `req_col`=0x0FE, `req_len`=5 → beats 0x0FE and 0x0FF (`beat_last` on 0x0FF), then `split` with `split_col`=0x100, `split_len`=3.
- `beat_ready` toggling 1,0,0,1 on a 3-beat burst from 0x020 → `beat_col` holds 0x021 through the stall, total 3 beats, `done` once.
- `req_col`=0xFFF, `cfg_colbits`=11, `req_len`=2 → beat 0xFFF, `split`, `split_col`=0x000 (wrap), `split_len`=1.
- `req_len`=0 → no `beat_valid`, `done` pulse in cycle N+1. `req_len`=1 at `page_end` → `done` only, no `split`.
- Reset asserted during the beat-2 stall → next cycle `beat_valid`=0, `req_ready`=1, no `done`/`split`. A new request then runs normally.
